// File: rtl/gnss_pkg.sv
// Shared GNSS definitions for the position-solver family.
//   state_t     : 4-bit FSM state encodings, common to pseudorange_generator
//                 and linear_solver debug state outputs
//   W_DEFAULT   : default signed coordinate width (integer metres)
//   diff_w()    : width of a coordinate difference (W+1)
//   sq_w()      : width of the exact sum of three squared differences (2W+4)
//   root_w()    : width of the integer square root of that sum (W+2)
package gnss_pkg;

    localparam int W_DEFAULT = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_DIFF  = 4'd1,
        ST_SQSUM = 4'd2,
        ST_ROOT  = 4'd3,
        ST_STORE = 4'd4,
        ST_DONE  = 4'd5
    } state_t;

    function automatic int diff_w(input int w);
        return w + 1;
    endfunction

    function automatic int sq_w(input int w);
        return 2 * w + 4;
    endfunction

    function automatic int root_w(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial restoring integer square root, one root bit per cycle, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture radicand and start (W+2 iterations follow)
//   radicand   : 2W+4-bit unsigned operand
//   root       : W+2-bit floor(sqrt(radicand)); final once valid is high
//   busy       : iterations in progress
//   last       : the current cycle computes the final root bit
//   valid      : root holds a finished result (held until the next load)
module isqrt_seq
    import gnss_pkg::*;
#(
    parameter int W = W_DEFAULT
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [2*W+3:0] radicand,
    output logic [W+1:0]   root,
    output logic           busy,
    output logic           last,
    output logic           valid
);

    localparam int SW = sq_w(W);
    localparam int RW = root_w(W);
    localparam int MW = RW + 2;
    localparam int CW = $clog2(RW + 1);

    logic [SW-1:0]   rad_sr;
    logic [MW-1:0]   rem;
    logic [RW-1:0]   q;
    logic [CW-1:0]   cnt;

    logic [MW+1:0]   rem_sh;
    logic [MW+1:0]   trial;
    logic            ge;
    logic [MW-1:0]   rem_n;
    logic [RW-1:0]   q_n;

    // One restoring step: bring down two radicand bits, try subtracting 4q+1.
    // The remainder never exceeds 2q, so truncating to MW bits loses nothing.
    always_comb begin
        rem_sh = {rem, rad_sr[SW-1 -: 2]};
        trial  = {2'b00, q, 2'b01};
        ge     = (rem_sh >= trial);
        rem_n  = ge ? MW'(rem_sh - trial) : MW'(rem_sh);
        q_n    = {q[RW-2:0], ge};
    end

    assign busy = (cnt != '0);
    assign last = (cnt == CW'(1));
    assign root = q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_sr <= '0;
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            rad_sr <= radicand;
            rem    <= '0;
            q      <= '0;
            cnt    <= CW'(RW);
            valid  <= 1'b0;
        end else if (busy) begin
            rad_sr <= {rad_sr[SW-3:0], 2'b00};
            rem    <= rem_n;
            q      <= q_n;
            cnt    <= cnt - CW'(1);
            valid  <= last;
        end
    end

endmodule

// File: rtl/pseudorange_generator.sv
// Forward model for the position solver: computes the four geometric ranges
// r_i = floor(sqrt((xi-c1)^2 + (yi-c2)^2 + (zi-c3)^2)) from a snapshot of the
// receiver and satellite positions, one satellite at a time through a shared
// difference / squared-sum datapath and a bit-serial square-root unit.
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : start request, sampled only in IDLE
//   c1..c3            : receiver position, W-bit signed
//   x1..x4,y1..y4,z1..z4 : satellite positions, W-bit signed
//   r1..r4            : W+2-bit unsigned ranges, updated satellite by satellite
//   done              : one-cycle pulse, r1..r4 form a coherent set
//   state             : current FSM encoding (debug)
module pseudorange_generator
    import gnss_pkg::*;
#(
    parameter int W = W_DEFAULT
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] c1,
    input  logic [W-1:0] c2,
    input  logic [W-1:0] c3,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] z1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] y2,
    input  logic [W-1:0] z2,
    input  logic [W-1:0] x3,
    input  logic [W-1:0] y3,
    input  logic [W-1:0] z3,
    input  logic [W-1:0] x4,
    input  logic [W-1:0] y4,
    input  logic [W-1:0] z4,
    output logic [W+1:0] r1,
    output logic [W+1:0] r2,
    output logic [W+1:0] r3,
    output logic [W+1:0] r4,
    output logic         done,
    output logic [3:0]   state
);

    localparam int DW = diff_w(W);
    localparam int SW = sq_w(W);
    localparam int RW = root_w(W);

    state_t st, nxt;

    logic signed [W-1:0]  cx, cy, cz;
    logic signed [W-1:0]  sx [4];
    logic signed [W-1:0]  sy [4];
    logic signed [W-1:0]  sz [4];
    logic [1:0]           k;

    logic signed [W-1:0]  xk, yk, zk;
    logic signed [DW-1:0] dx_p1, dy_p1, dz_p1;
    logic signed [SW-1:0] dxe, dye, dze;
    logic [SW-1:0]        sqsum_p2;

    logic                 root_load;
    logic [RW-1:0]        root;
    logic                 root_busy;
    logic                 root_last;
    logic                 root_valid;

    assign xk = sx[k];
    assign yk = sy[k];
    assign zk = sz[k];

    // SQSUM stage: squares of sign-extended differences; the sum of three
    // squares of (W+1)-bit values is below 3*2^(2W), exact in 2W+4 bits.
    always_comb begin
        dxe      = SW'(dx_p1);
        dye      = SW'(dy_p1);
        dze      = SW'(dz_p1);
        sqsum_p2 = SW'(dxe * dxe + dye * dye + dze * dze);
    end

    assign root_load = (st == ST_SQSUM);
    assign done      = (st == ST_DONE);
    assign state     = st;

    isqrt_seq #(.W(W)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (root_load),
        .radicand (sqsum_p2),
        .root     (root),
        .busy     (root_busy),
        .last     (root_last),
        .valid    (root_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ST_IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            ST_IDLE:  if (en) nxt = ST_DIFF;
            ST_DIFF:  nxt = ST_SQSUM;
            ST_SQSUM: nxt = ST_ROOT;
            ST_ROOT: begin
                // Leave on the edge that produces the final root bit.
                if (root_last)       nxt = ST_STORE;
                else if (!root_busy) nxt = ST_IDLE;
            end
            ST_STORE: nxt = (k == 2'd3) ? ST_DONE : ST_DIFF;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx    <= '0;
            cy    <= '0;
            cz    <= '0;
            for (int i = 0; i < 4; i++) begin
                sx[i] <= '0;
                sy[i] <= '0;
                sz[i] <= '0;
            end
            k     <= '0;
            dx_p1 <= '0;
            dy_p1 <= '0;
            dz_p1 <= '0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            r4    <= '0;
        end else begin
            // Snapshot: inputs are free to change once the run is accepted.
            if (st == ST_IDLE && en) begin
                cx    <= c1;
                cy    <= c2;
                cz    <= c3;
                sx[0] <= x1;
                sy[0] <= y1;
                sz[0] <= z1;
                sx[1] <= x2;
                sy[1] <= y2;
                sz[1] <= z2;
                sx[2] <= x3;
                sy[2] <= y3;
                sz[2] <= z3;
                sx[3] <= x4;
                sy[3] <= y4;
                sz[3] <= z4;
                k     <= '0;
            end

            // DIFF stage: one extra bit makes the subtraction overflow-free.
            if (st == ST_DIFF) begin
                dx_p1 <= DW'(xk) - DW'(cx);
                dy_p1 <= DW'(yk) - DW'(cy);
                dz_p1 <= DW'(zk) - DW'(cz);
            end

            // STORE stage: only the current satellite's range changes.
            if (st == ST_STORE) begin
                if (root_valid) begin
                    case (k)
                        2'd0:    r1 <= root;
                        2'd1:    r2 <= root;
                        2'd2:    r3 <= root;
                        default: r4 <= root;
                    endcase
                end
                if (k != 2'd3) k <= k + 2'd1;
            end
        end
    end

endmodule
